// File: rtl/loop_stmt_engine.sv
// ---------------------------------------------------------------------------
// loop_stmt_engine
//   Multi-mode loop execution block. The single-pass modes run the whole
//   loop combinationally when a request is accepted. The iterative modes
//   advance one loop iteration per clock under a three-state FSM.
//
//   Modes:
//     0 FOR_SUM     : sum the non-zero lanes (zero lanes are skipped)
//     1 FIND_FIRST  : index of the first lane above threshold
//     2 REPEAT_ACC  : add lane0 to the accumulator min(count_i, MAX_ITER) times
//     3 WHILE_HALVE : halve lane0 while it is >= threshold, bounded by MAX_ITER
//
//   Handshake: a request is accepted only when the block is idle and start is
//   sampled high on a rising edge. busy is high while iterating. done pulses
//   for exactly one cycle. result, iters and flag then hold until the next
//   accepted request. A start seen while busy or done is dropped and is not
//   queued.
//
//   Ports:
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     start          request strobe, sampled only in IDLE
//     mode[1:0]      operation select
//     lanes_i        LANES operands; lane k = lanes_i[k*WIDTH +: WIDTH]
//     threshold      compare value for modes 1 and 3
//     count_i        repeat count for mode 2, saturated to MAX_ITER
//     busy, done     status and completion pulse
//     result         mode result
//     iters          loop iterations executed or counted
//     flag           mode 1 no-match / mode 3 timeout
// ---------------------------------------------------------------------------
module loop_stmt_engine #(
  parameter int WIDTH    = 8,
  parameter int LANES    = 4,
  parameter int MAX_ITER = 15,
  localparam int IW      = $clog2(MAX_ITER + 1),
  localparam int MAXV    = (LANES > MAX_ITER + 1) ? LANES : MAX_ITER + 1,
  localparam int RES_W   = WIDTH + $clog2(MAXV)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] lanes_i,
  input  logic [WIDTH-1:0]       threshold,
  input  logic [IW-1:0]          count_i,
  output logic                   busy,
  output logic                   done,
  output logic [RES_W-1:0]       result,
  output logic [IW-1:0]          iters,
  output logic                   flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_FOR_SUM    = 2'd0;
  localparam logic [1:0] M_FIND_FIRST = 2'd1;
  localparam logic [1:0] M_REPEAT_ACC = 2'd2;
  localparam int         IW_MAX       = (2 ** IW) - 1;

  state_t               state, state_n;
  logic [1:0]           mode_q;
  logic [WIDTH-1:0]     lane0_q;
  logic [WIDTH-1:0]     thr_q;
  logic [WIDTH-1:0]     val_q;
  logic [IW-1:0]        cnt_q;

  logic [IW-1:0]        eff_cnt;
  logic [RES_W-1:0]     sum_comb;
  logic [IW-1:0]        sum_iters;
  logic                 ff_found;
  logic [RES_W-1:0]     ff_result;
  logic [IW-1:0]        ff_iters;
  logic                 accept;
  logic                 rep_last;
  logic                 wh_below;
  logic                 wh_tmo;

  // Iteration counts can exceed what IW bits hold when LANES > MAX_ITER.
  function automatic logic [IW-1:0] sat_iw(input int v);
    return (v > IW_MAX) ? IW'(IW_MAX) : IW'(v);
  endfunction

  assign eff_cnt = (count_i > IW'(MAX_ITER)) ? IW'(MAX_ITER) : count_i;
  assign accept  = (state == IDLE) && start;

  // Single-pass loops, evaluated on the live inputs; their results are
  // registered only on the accepting edge.
  always_comb begin
    int nz;
    int idx;
    sum_comb = '0;
    nz       = 0;
    idx      = 0;
    ff_found = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (lanes_i[k*WIDTH +: WIDTH] != '0) begin
        sum_comb = sum_comb + RES_W'(lanes_i[k*WIDTH +: WIDTH]);
        nz       = nz + 1;
      end
      // Only the first lane above threshold counts; later matches are ignored.
      if (!ff_found && (lanes_i[k*WIDTH +: WIDTH] > threshold)) begin
        ff_found = 1'b1;
        idx      = k;
      end
    end
    sum_iters = sat_iw(nz);
    ff_result = ff_found ? RES_W'(idx) : '0;
    ff_iters  = ff_found ? sat_iw(idx + 1) : sat_iw(LANES);
  end

  // Loop exit tests for the iterative modes. The while-loop condition is
  // checked before each step, so a value already below threshold exits with
  // zero iterations.
  assign rep_last = (iters + IW'(1)) == cnt_q;
  assign wh_below = val_q < thr_q;
  assign wh_tmo   = iters == IW'(MAX_ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (mode == M_FOR_SUM || mode == M_FIND_FIRST) state_n = DONE;
          else if (mode == M_REPEAT_ACC && eff_cnt == '0) state_n = DONE;
          else state_n = ITER;
        end
      end
      ITER: begin
        if (mode_q == M_REPEAT_ACC) begin
          if (rep_last) state_n = DONE;
        end else begin
          if (wh_below || wh_tmo) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == ITER);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      lane0_q <= '0;
      thr_q   <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
      result  <= '0;
      iters   <= '0;
      flag    <= 1'b0;
    end else if (accept) begin
      mode_q  <= mode;
      lane0_q <= lanes_i[WIDTH-1:0];
      thr_q   <= threshold;
      val_q   <= lanes_i[WIDTH-1:0];
      cnt_q   <= eff_cnt;
      case (mode)
        M_FOR_SUM: begin
          result <= sum_comb;
          iters  <= sum_iters;
          flag   <= 1'b0;
        end
        M_FIND_FIRST: begin
          result <= ff_result;
          iters  <= ff_iters;
          flag   <= !ff_found;
        end
        default: begin
          result <= '0;
          iters  <= '0;
          flag   <= 1'b0;
        end
      endcase
    end else if (state == ITER) begin
      if (mode_q == M_REPEAT_ACC) begin
        // result doubles as the accumulator; RES_W covers MAX_ITER * lane max.
        result <= result + RES_W'(lane0_q);
        iters  <= iters + IW'(1);
      end else if (wh_below) begin
        result <= RES_W'(val_q);
        flag   <= 1'b0;
      end else if (wh_tmo) begin
        result <= RES_W'(val_q);
        flag   <= 1'b1;
      end else begin
        val_q <= val_q >> 1;
        iters <= iters + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_loop_stmt_engine.sv
// ---------------------------------------------------------------------------
// tb_loop_stmt_engine
//   Directed bench for loop_stmt_engine at default parameters
//   (WIDTH=8, LANES=4, MAX_ITER=15 -> IW=4, RES_W=12).
//   Latency is reported as the number of clock edges after the accepting
//   edge before done is seen (0 means done in the cycle right after accept).
// ---------------------------------------------------------------------------
module tb_loop_stmt_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] lanes_i;
  logic [7:0]  threshold;
  logic [3:0]  count_i;
  logic        busy;
  logic        done;
  logic [11:0] result;
  logic [3:0]  iters;
  logic        flag;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int bcnt;

  loop_stmt_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .lanes_i   (lanes_i),
    .threshold (threshold),
    .count_i   (count_i),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .iters     (iters),
    .flag      (flag)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; counts edges waited and cycles seen busy.
  task automatic wait_done(output int c, output int b);
    c = 0;
    b = 0;
    while (done !== 1'b1 && c < 100) begin
      if (busy === 1'b1) b++;
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 100) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic issue(input logic [1:0] m, input logic [31:0] l,
                       input logic [7:0] t, input logic [3:0] c);
    @(negedge clk);
    mode      = m;
    lanes_i   = l;
    threshold = t;
    count_i   = c;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full operation; inputs are scrambled after capture, and the cycle after
  // done is checked for a single-cycle pulse.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] l,
                        input logic [7:0] t, input logic [3:0] c,
                        output int cy, output int bc);
    issue(m, l, t, c);
    mode      = 2'($urandom_range(0, 3));
    lanes_i   = $urandom;
    threshold = 8'($urandom_range(0, 255));
    count_i   = 4'($urandom_range(0, 15));
    wait_done(cy, bc);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    lanes_i   = '0;
    threshold = '0;
    count_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_iters",  32'(iters),  32'd0);
    chk("rst_flag",   32'(flag),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mode 0: lanes 0,5,0,7
    run_op("m0a", 2'd0, {8'd7, 8'd0, 8'd5, 8'd0}, 8'd0, 4'd0, cyc, bcnt);
    chk("m0a_lat",    32'(cyc),    32'd0);
    chk("m0a_result", 32'(result), 32'd12);
    chk("m0a_iters",  32'(iters),  32'd2);
    chk("m0a_flag",   32'(flag),   32'd0);

    // mode 0: all lanes 255
    run_op("m0b", 2'd0, 32'hFFFF_FFFF, 8'd0, 4'd0, cyc, bcnt);
    chk("m0b_result", 32'(result), 32'd1020);
    chk("m0b_iters",  32'(iters),  32'd4);

    // mode 1: threshold 6, lanes 3,9,2,10
    run_op("m1a", 2'd1, {8'd10, 8'd2, 8'd9, 8'd3}, 8'd6, 4'd0, cyc, bcnt);
    chk("m1a_lat",    32'(cyc),    32'd0);
    chk("m1a_result", 32'(result), 32'd1);
    chk("m1a_iters",  32'(iters),  32'd2);
    chk("m1a_flag",   32'(flag),   32'd0);

    // mode 1: no match
    run_op("m1b", 2'd1, {8'd10, 8'd2, 8'd9, 8'd3}, 8'd200, 4'd0, cyc, bcnt);
    chk("m1b_result", 32'(result), 32'd0);
    chk("m1b_iters",  32'(iters),  32'd4);
    chk("m1b_flag",   32'(flag),   32'd1);

    // mode 2: 200 x 5
    run_op("m2a", 2'd2, {24'h0, 8'd200}, 8'd0, 4'd5, cyc, bcnt);
    chk("m2a_lat",    32'(cyc),    32'd5);
    chk("m2a_busy",   32'(bcnt),   32'd5);
    chk("m2a_result", 32'(result), 32'd1000);
    chk("m2a_iters",  32'(iters),  32'd5);
    chk("m2a_flag",   32'(flag),   32'd0);

    // mode 2: zero count
    run_op("m2b", 2'd2, {24'h0, 8'd200}, 8'd0, 4'd0, cyc, bcnt);
    chk("m2b_lat",    32'(cyc),    32'd0);
    chk("m2b_result", 32'(result), 32'd0);
    chk("m2b_iters",  32'(iters),  32'd0);

    // mode 2: 255 x 15
    run_op("m2c", 2'd2, {24'h0, 8'd255}, 8'd0, 4'd15, cyc, bcnt);
    chk("m2c_lat",    32'(cyc),    32'd15);
    chk("m2c_result", 32'(result), 32'd3825);
    chk("m2c_iters",  32'(iters),  32'd15);

    // mode 3: 200 halved below 10 -> 100,50,25,12,6
    run_op("m3a", 2'd3, {24'h0, 8'd200}, 8'd10, 4'd0, cyc, bcnt);
    chk("m3a_lat",    32'(cyc),    32'd6);
    chk("m3a_result", 32'(result), 32'd6);
    chk("m3a_iters",  32'(iters),  32'd5);
    chk("m3a_flag",   32'(flag),   32'd0);

    // mode 3: threshold 0 never satisfied -> timeout
    run_op("m3b", 2'd3, {24'h0, 8'd200}, 8'd0, 4'd0, cyc, bcnt);
    chk("m3b_lat",    32'(cyc),    32'd16);
    chk("m3b_result", 32'(result), 32'd0);
    chk("m3b_iters",  32'(iters),  32'd15);
    chk("m3b_flag",   32'(flag),   32'd1);

    // mode 3: already below threshold at capture
    run_op("m3c", 2'd3, {24'h0, 8'd5}, 8'd10, 4'd0, cyc, bcnt);
    chk("m3c_lat",    32'(cyc),    32'd1);
    chk("m3c_result", 32'(result), 32'd5);
    chk("m3c_iters",  32'(iters),  32'd0);

    // start while busy and while done is ignored
    issue(2'd2, {24'h0, 8'd200}, 8'd0, 4'd5);
    repeat (2) @(posedge clk);
    #1;
    issue(2'd0, 32'h0101_0101, 8'd0, 4'd0);
    wait_done(cyc, bcnt);
    chk("bsy_result", 32'(result), 32'd1000);
    chk("bsy_iters",  32'(iters),  32'd5);
    issue(2'd0, 32'h0101_0101, 8'd0, 4'd0);
    chk("dn_ign_done",   32'(done),   32'd0);
    chk("dn_ign_result", 32'(result), 32'd1000);
    run_op("post", 2'd0, 32'h0101_0101, 8'd0, 4'd0, cyc, bcnt);
    chk("post_result", 32'(result), 32'd4);
    chk("post_iters",  32'(iters),  32'd4);

    // async reset mid mode 2 at iters=3
    issue(2'd2, {24'h0, 8'd200}, 8'd0, 4'd15);
    cyc = 0;
    while (iters !== 4'd3 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid_iters3", 32'(iters), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(busy),   32'd0);
    chk("mid_rst_done",   32'(done),   32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_iters",  32'(iters),  32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mid_rst_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_done", 32'(done), 32'd0);
    run_op("rel", 2'd0, {8'd7, 8'd0, 8'd5, 8'd0}, 8'd0, 4'd0, cyc, bcnt);
    chk("rel_lat",    32'(cyc),    32'd0);
    chk("rel_result", 32'(result), 32'd12);
    chk("rel_iters",  32'(iters),  32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
